// File: rtl/pwm_hbridge_drive.sv
// pwm_hbridge_drive
// Converts a signed 16-bit command (typically a PID output) into a PWM gate
// plus direction bit for an H-bridge. Commands are double-buffered in a
// shadow register and applied only at PWM period boundaries. A dead-time
// window is inserted at the start of any period in which direction reverses.
// A one-cycle period_start strobe marks period index 0 and can serve as the
// control loop's sample tick.

module pwm_hbridge_drive #(
    parameter int PERIOD_BITS = 10,
    parameter int DEADTIME    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [15:0]            cmd,
    input  logic                   cmd_valid,
    output logic                   pwm,
    output logic                   dir,
    output logic                   period_start,
    output logic [PERIOD_BITS-1:0] duty
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [PERIOD_BITS-1:0] K_MAX  = {PERIOD_BITS{1'b1}};
    localparam logic [PERIOD_BITS-1:0] K_ZERO = {PERIOD_BITS{1'b0}};
    localparam logic [PERIOD_BITS-1:0] K_ONE  = {{(PERIOD_BITS-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_BITS-1:0] DEAD_K = PERIOD_BITS'(DEADTIME);

    // |c| as a 15-bit unsigned value; -32768 saturates to 32767.
    function automatic logic [14:0] abs_sat(input logic [15:0] c);
        logic [15:0] neg;
        neg = ~c + 16'd1;
        if (c == 16'h8000) begin
            return 15'h7fff;
        end else if (c[15]) begin
            return neg[14:0];
        end else begin
            return c[14:0];
        end
    endfunction

    state_t                   state_r, state_nxt_s;
    logic [PERIOD_BITS-1:0]   k_r, k_nxt_s;
    logic [15:0]              shadow_r;
    logic                     dir_r, dir_nxt_s;
    logic [PERIOD_BITS-1:0]   duty_r, duty_nxt_s;
    logic                     pwm_r, pwm_nxt_s;
    logic                     ps_r, ps_nxt_s;

    logic                     boundary_s;
    logic [15:0]              load_cmd_s;
    logic [14:0]              load_mag_s;
    logic [PERIOD_BITS-1:0]   load_duty_s;
    logic                     load_sign_s;
    logic                     unused_mag_s;

    // A command presented on the boundary cycle itself bypasses the shadow.
    assign boundary_s   = en & ((k_r == K_MAX) | (state_r == IDLE));
    assign load_cmd_s   = cmd_valid ? cmd : shadow_r;
    assign load_mag_s   = abs_sat(load_cmd_s);
    assign load_duty_s  = load_mag_s[14 -: PERIOD_BITS];
    assign load_sign_s  = load_cmd_s[15];
    // Magnitude bits below the duty resolution are dropped on purpose.
    assign unused_mag_s = ^load_mag_s;

    // Shadow register: captures cmd on every valid cycle, enabled or not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r <= 16'h0000;
        end else if (cmd_valid) begin
            shadow_r <= cmd;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Next state, period counter, applied command and registered output values.
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        dir_nxt_s   = dir_r;
        duty_nxt_s  = duty_r;
        ps_nxt_s    = 1'b0;
        pwm_nxt_s   = 1'b0;

        if (!en) begin
            state_nxt_s = IDLE;
            k_nxt_s     = K_ZERO;
        end else if (boundary_s) begin
            k_nxt_s    = K_ZERO;
            ps_nxt_s   = 1'b1;
            duty_nxt_s = load_duty_s;
            // Zero duty never drives the bridge, so it keeps the old direction.
            if ((load_duty_s != K_ZERO) && (load_sign_s != dir_r)) begin
                dir_nxt_s   = load_sign_s;
                state_nxt_s = DEAD;
            end else begin
                state_nxt_s = RUN;
            end
        end else begin
            k_nxt_s = k_r + K_ONE;
        end

        // pwm is computed from the next k so it lines up with period_start.
        case (state_nxt_s)
            RUN:     pwm_nxt_s = (k_nxt_s < duty_nxt_s);
            DEAD:    pwm_nxt_s = (k_nxt_s >= DEAD_K) && (k_nxt_s < duty_nxt_s);
            IDLE:    pwm_nxt_s = 1'b0;
            default: pwm_nxt_s = 1'b0;
        endcase
    end

    // State, counter and registered outputs; reset forces the bridge off at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            k_r     <= K_ZERO;
            dir_r   <= 1'b0;
            duty_r  <= K_ZERO;
            pwm_r   <= 1'b0;
            ps_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            k_r     <= k_nxt_s;
            dir_r   <= dir_nxt_s;
            duty_r  <= duty_nxt_s;
            pwm_r   <= pwm_nxt_s;
            ps_r    <= ps_nxt_s;
        end
    end

    assign pwm          = pwm_r;
    assign dir          = dir_r;
    assign period_start = ps_r;
    assign duty         = duty_r;

endmodule
